conv_out_quant: RTL

- Parametrised successor to the conv output value gate: multi-channel output requantiser at the tail of the ip_conv datapath.
- Takes signed accumulator words for CH channels per beat and applies optional ReLU, rounding arithmetic right shift and saturation to OUT_WIDTH.
- Buffers results in a 2-entry output queue behind a valid/ready handshake, so the downstream stage can stall without dropping data.
- Counts saturation events for debug.

---
 rtl/conv_pkg.sv | 51 +++++
 rtl/conv_out_fifo2.sv | 69 ++++++
 rtl/conv_out_quant.sv | 87 ++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared definitions for the ip_conv datapath tail stages.
// Holds the default quantiser widths/shift and sat_round(), the
// ReLU + round-half-up arithmetic shift + saturate primitive that any
// conv stage can reuse regardless of its own word widths.
package conv_pkg;

    localparam int QIN_WIDTH  = 16;
    localparam int QOUT_WIDTH = 8;
    localparam int QSHIFT     = 4;
    localparam int QCNT_WIDTH = 16;

    // Working width of sat_round(): callers sign-extend inputs of up to
    // QCALC_W bits; one extra bit keeps the rounding add from overflowing.
    localparam int QCALC_W = 32;

    // {sat, value}; value is sign-extended, callers keep the low out_w bits.
    typedef logic [QCALC_W:0] qres_t;

    function automatic qres_t sat_round(input logic signed [QCALC_W-1:0] x,
                                        input logic                      mode,
                                        input int                        shift,
                                        input int                        out_w);
        logic signed [QCALC_W:0] r;
        logic signed [QCALC_W:0] t;
        logic signed [QCALC_W:0] hi;
        logic signed [QCALC_W:0] lo;
        logic                    sat;
        logic [QCALC_W-1:0]      v;

        r = (mode && x[QCALC_W-1]) ? '0 : {x[QCALC_W-1], x};
        // Adding half an LSB before the floor shift rounds ties toward +inf.
        if (shift > 0)
            r = r + (33'sd1 <<< (shift - 1));
        t  = r >>> shift;
        hi = (33'sd1 <<< (out_w - 1)) - 33'sd1;
        lo = -(33'sd1 <<< (out_w - 1));

        if (t > hi) begin
            sat = 1'b1;
            v   = hi[QCALC_W-1:0];
        end else if (t < lo) begin
            sat = 1'b1;
            v   = lo[QCALC_W-1:0];
        end else begin
            sat = 1'b0;
            v   = t[QCALC_W-1:0];
        end
        return {sat, v};
    endfunction

endpackage

// File: rtl/conv_out_fifo2.sv
// conv_out_fifo2: 2-entry valid/ready queue.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   wr_valid/wr_ready    write handshake; wr_ready depends on occupancy only
//   wr_data  [W]         write payload
//   rd_valid/rd_ready    read handshake; rd_valid = queue not empty
//   rd_data  [W]         head entry, registered, stable while not popped
module conv_out_fifo2 #(
    parameter int W = 36
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic [W-1:0] wr_data,
    output logic         rd_valid,
    input  logic         rd_ready,
    output logic [W-1:0] rd_data
);

    logic [1:0]   count;
    logic [W-1:0] head;
    logic [W-1:0] tail;
    logic         push;
    logic         pop;

    assign wr_ready = (count != 2'd2);
    assign rd_valid = (count != 2'd0);
    assign rd_data  = head;
    assign push     = wr_valid & wr_ready;
    assign pop      = rd_valid & rd_ready;

    // The head register always drives the output, so a stalled head never
    // moves; the second slot only feeds the head when the head is popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else begin
            case (count)
                2'd0: begin
                    if (push) begin
                        head  <= wr_data;
                        count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head <= wr_data;
                    end else if (push) begin
                        tail  <= wr_data;
                        count <= 2'd2;
                    end else if (pop) begin
                        count <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        head  <= tail;
                        count <= 2'd1;
                    end
                end
                default: count <= 2'd0;
            endcase
        end
    end

endmodule

// File: rtl/conv_out_quant.sv
// conv_out_quant: multi-channel output requantiser at the tail of ip_conv.
// Each accepted beat carries CH signed IN_WIDTH accumulators; every channel
// gets optional ReLU, a round-half-up arithmetic right shift by SHIFT and
// saturation to OUT_WIDTH. Results sit in a 2-entry queue behind a
// valid/ready handshake, and beats with any saturated channel are counted.
// Ports:
//   iclk, irst_n         clock, asynchronous active-low reset
//   ivalid, oready       upstream handshake (oready from registered state)
//   ivalue [CH*IN_WIDTH] packed inputs, channel k at [k*IN_WIDTH +: IN_WIDTH]
//   imode                1 = ReLU, sampled with each accepted beat
//   ovalid, iready       downstream handshake
//   ovalue [CH*OUT_WIDTH] packed results, same channel order
//   osat   [CH]          per-channel saturation flags of the head beat
//   iclr                 synchronous clear of osat_cnt (wins over increment)
//   osat_cnt [CNT_WIDTH] saturating count of beats with any channel saturated
// IN_WIDTH and OUT_WIDTH must not exceed the package working width (32).
module conv_out_quant
    import conv_pkg::*;
#(
    parameter int CH        = 4,
    parameter int IN_WIDTH  = QIN_WIDTH,
    parameter int OUT_WIDTH = QOUT_WIDTH,
    parameter int SHIFT     = QSHIFT,
    parameter int CNT_WIDTH = QCNT_WIDTH
) (
    input  logic                    iclk,
    input  logic                    irst_n,
    input  logic                    ivalid,
    output logic                    oready,
    input  logic [CH*IN_WIDTH-1:0]  ivalue,
    input  logic                    imode,
    output logic                    ovalid,
    input  logic                    iready,
    output logic [CH*OUT_WIDTH-1:0] ovalue,
    output logic [CH-1:0]           osat,
    input  logic                    iclr,
    output logic [CNT_WIDTH-1:0]    osat_cnt
);

    localparam int PW = CH*OUT_WIDTH + CH;

    logic [CH*OUT_WIDTH-1:0] q_val;
    logic [CH-1:0]           q_sat;
    logic [PW-1:0]           head;
    logic                    push;

    assign push = ivalid & oready;

    for (genvar k = 0; k < CH; k++) begin : g_lane
        logic signed [IN_WIDTH-1:0]       x;
        qres_t                            res;
        logic [QCALC_W-OUT_WIDTH-1:0]     res_unused;

        assign x          = ivalue[k*IN_WIDTH +: IN_WIDTH];
        assign res        = sat_round(QCALC_W'(x), imode, SHIFT, OUT_WIDTH);
        assign q_val[k*OUT_WIDTH +: OUT_WIDTH] = res[OUT_WIDTH-1:0];
        assign q_sat[k]   = res[QCALC_W];
        // Sign-extension bits above OUT_WIDTH carry no information.
        assign res_unused = res[QCALC_W-1:OUT_WIDTH];
    end

    conv_out_fifo2 #(
        .W(PW)
    ) u_fifo (
        .clk      (iclk),
        .rst_n    (irst_n),
        .wr_valid (ivalid),
        .wr_ready (oready),
        .wr_data  ({q_sat, q_val}),
        .rd_valid (ovalid),
        .rd_ready (iready),
        .rd_data  (head)
    );

    assign {osat, ovalue} = head;

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            osat_cnt <= '0;
        end else if (iclr) begin
            osat_cnt <= '0;
        end else if (push && (|q_sat) && (osat_cnt != '1)) begin
            osat_cnt <= osat_cnt + 1'b1;
        end
    end

endmodule
